// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared types and constants for the AES-128 round sequencer.
//   aes_sched_state_t : sequencer FSM states
//   aes_sched_strb_t  : registered output strobes, one bit per datapath step
//   aes_sched_decode  : state -> strobe decode. The FSM applies it to the
//                       next state, so strobes are registered and line up
//                       with the state register.
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_NO_ROUNDS = 10;
  localparam int AES_NO_ROWS   = 4;
  localparam int AES_NO_COLS   = 4;
  localparam int AES_ROUND_W   = 4;
  localparam int AES_TMR_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEY   = 3'd1,
    ST_ADD   = 3'd2,
    ST_SUB   = 3'd3,
    ST_SHIFT = 3'd4,
    ST_MIX   = 3'd5,
    ST_DONE  = 3'd6
  } aes_sched_state_t;

  typedef struct packed {
    logic key_req;
    logic sbox_en;
    logic shift_rows;
    logic mix_col;
    logic add_key;
    logic busy;
    logic cipher_rdy;
  } aes_sched_strb_t;

  function automatic aes_sched_strb_t aes_sched_decode(input aes_sched_state_t st);
    aes_sched_strb_t s;
    s      = '0;
    s.busy = (st != ST_IDLE);
    case (st)
      ST_KEY:   s.key_req    = 1'b1;
      ST_ADD:   s.add_key    = 1'b1;
      ST_SUB:   s.sbox_en    = 1'b1;
      ST_SHIFT: s.shift_rows = 1'b1;
      ST_MIX:   s.mix_col    = 1'b1;
      ST_DONE:  s.cipher_rdy = 1'b1;
      default:  s            = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/aes_sched_timer.sv
// ---------------------------------------------------------------------------
// aes_sched_timer
// Loadable, clearable down-counter that bounds how long the sequencer waits
// for a round key.
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous active-high reset (count -> 0)
//   clr_i      : synchronous clear (highest priority)
//   load_i     : load load_val_i
//   load_val_i : reload value
//   dec_i      : decrement by one, saturating at zero
//   expire_o   : count is zero
// ---------------------------------------------------------------------------
module aes_sched_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/aes_round_sched.sv
// ---------------------------------------------------------------------------
// aes_round_sched
// Round sequencer for the AES-128 encryption core: initial AddRoundKey,
// rounds 1..NO_ROUNDS-1 (Sub/Shift/Mix/AddKey), final round without
// MixColumns. Handshakes with the key expansion unit (req/vld) and the sbox
// (enable/done). All outputs come from registers.
//   aes_clk           : clock, rising edge
//   reset             : asynchronous active-high reset
//   aes_core_en       : core enable; low aborts to IDLE at the next edge
//   start_i           : start encryption, sampled only in IDLE
//   key_vld_i         : round key for round_num_o is valid (KEY only)
//   key_req_o         : round key request
//   sbox_done_i       : sbox result valid (SUB only)
//   sbox_en_o         : sbox enable, held until sbox_done_i
//   shift_rows_en_o   : ShiftRows strobe
//   mix_col_en_o      : MixColumns strobe
//   add_key_en_o      : AddRoundKey strobe
//   round_num_o       : current round 0..NO_ROUNDS
//   busy_o            : high outside IDLE
//   cipher_text_rdy_o : one-cycle pulse, cipher state final
//   key_err_o         : one-cycle pulse on key timeout
// ---------------------------------------------------------------------------
module aes_round_sched
  import aes_pkg::*;
#(
  parameter int NO_ROUNDS   = AES_NO_ROUNDS,
  parameter int KEY_TIMEOUT = 255
) (
  input  logic                   aes_clk,
  input  logic                   reset,
  input  logic                   aes_core_en,
  input  logic                   start_i,
  input  logic                   key_vld_i,
  output logic                   key_req_o,
  input  logic                   sbox_done_i,
  output logic                   sbox_en_o,
  output logic                   shift_rows_en_o,
  output logic                   mix_col_en_o,
  output logic                   add_key_en_o,
  output logic [AES_ROUND_W-1:0] round_num_o,
  output logic                   busy_o,
  output logic                   cipher_text_rdy_o,
  output logic                   key_err_o
);

  localparam logic [AES_ROUND_W-1:0] LAST_ROUND = AES_ROUND_W'(NO_ROUNDS);
  // Timer expires when it reaches zero, so loading KEY_TIMEOUT-1 gives
  // exactly KEY_TIMEOUT waiting cycles in KEY.
  localparam logic [AES_TMR_W-1:0]   TMO_LOAD   = AES_TMR_W'(KEY_TIMEOUT - 1);

  aes_sched_state_t       state_q, state_d;
  logic [AES_ROUND_W-1:0] round_q, round_d;
  aes_sched_strb_t        strb_q, strb_d;
  logic                   key_err_q, key_err_d;

  logic tmr_clr;
  logic tmr_load;
  logic tmr_dec;
  logic tmr_expire;

  aes_sched_timer #(
    .CNT_W (AES_TMR_W)
  ) u_timer (
    .clk_i      (aes_clk),
    .rst_i      (reset),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .load_val_i (TMO_LOAD),
    .dec_i      (tmr_dec),
    .expire_o   (tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    key_err_d = 1'b0;
    tmr_clr   = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;

    if (!aes_core_en) begin
      // Abort takes priority over every in-flight step, including a
      // pending timeout, so no error or ready pulse follows it.
      state_d = ST_IDLE;
      round_d = '0;
      tmr_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d  = ST_KEY;
            round_d  = '0;
            tmr_load = 1'b1;
          end
        end

        ST_KEY: begin
          // A key arriving in the expiry cycle is still accepted.
          if (key_vld_i) begin
            state_d = ST_ADD;
          end else if (tmr_expire) begin
            state_d   = ST_IDLE;
            round_d   = '0;
            key_err_d = 1'b1;
            tmr_clr   = 1'b1;
          end else begin
            tmr_dec = 1'b1;
          end
        end

        ST_ADD: begin
          if (round_q < LAST_ROUND) begin
            round_d = round_q + AES_ROUND_W'(1);
            state_d = ST_SUB;
          end else begin
            state_d = ST_DONE;
          end
        end

        ST_SUB: begin
          if (sbox_done_i) begin
            state_d = ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          // The final round skips MixColumns and goes straight for its key.
          if (round_q < LAST_ROUND) begin
            state_d = ST_MIX;
          end else begin
            state_d  = ST_KEY;
            tmr_load = 1'b1;
          end
        end

        ST_MIX: begin
          state_d  = ST_KEY;
          tmr_load = 1'b1;
        end

        ST_DONE: begin
          // Round stays at NO_ROUNDS until the next start.
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
          round_d = '0;
        end
      endcase
    end
  end

  assign strb_d = aes_sched_decode(state_d);

  always_ff @(posedge aes_clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      round_q   <= '0;
      strb_q    <= '0;
      key_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      strb_q    <= strb_d;
      key_err_q <= key_err_d;
    end
  end

  assign key_req_o         = strb_q.key_req;
  assign sbox_en_o         = strb_q.sbox_en;
  assign shift_rows_en_o   = strb_q.shift_rows;
  assign mix_col_en_o      = strb_q.mix_col;
  assign add_key_en_o      = strb_q.add_key;
  assign busy_o            = strb_q.busy;
  assign cipher_text_rdy_o = strb_q.cipher_rdy;
  assign key_err_o         = key_err_q;
  assign round_num_o       = round_q;

endmodule

// File: tb/tb_aes_round_sched.sv
// ---------------------------------------------------------------------------
// tb_aes_round_sched
// Scoreboard bench: stimulus pushes the expected event stream, a monitor on
// the falling edge turns DUT outputs into events and compares them in order.
// ---------------------------------------------------------------------------
module tb_aes_round_sched;

  logic       aes_clk = 1'b0;
  logic       reset = 1'b1;
  logic       aes_core_en = 1'b0;
  logic       start_i = 1'b0;
  logic       key_vld_i = 1'b0;
  logic       sbox_done_i = 1'b0;
  logic       key_req_o, sbox_en_o, shift_rows_en_o, mix_col_en_o, add_key_en_o;
  logic [3:0] round_num_o;
  logic       busy_o, cipher_text_rdy_o, key_err_o;

  aes_round_sched #(
    .NO_ROUNDS   (10),
    .KEY_TIMEOUT (255)
  ) dut (
    .aes_clk           (aes_clk),
    .reset             (reset),
    .aes_core_en       (aes_core_en),
    .start_i           (start_i),
    .key_vld_i         (key_vld_i),
    .key_req_o         (key_req_o),
    .sbox_done_i       (sbox_done_i),
    .sbox_en_o         (sbox_en_o),
    .shift_rows_en_o   (shift_rows_en_o),
    .mix_col_en_o      (mix_col_en_o),
    .add_key_en_o      (add_key_en_o),
    .round_num_o       (round_num_o),
    .busy_o            (busy_o),
    .cipher_text_rdy_o (cipher_text_rdy_o),
    .key_err_o         (key_err_o)
  );

  always #5 aes_clk = ~aes_clk;

  localparam int EV_REQ = 0, EV_SBX = 1, EV_ADD = 2, EV_SHIFT = 3,
                 EV_MIX = 4, EV_DONE = 5, EV_ERR = 6;

  typedef struct {
    int kind;
    int rnd;
    int len;   // expected handshake length, 0 = not applicable
    int lat;   // expected cycles from start edge, -1 = not applicable
  } ev_t;

  ev_t exp_q[$];

  int n_total = 0;
  int n_pass  = 0;
  int cyc = 0;
  int start_cyc = 0;
  int key_dly = 0;
  int sbox_dly = 0;
  int kcnt = 0;
  int scnt = 0;

  always @(posedge aes_clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void push_ev(input int kind, input int rnd, input int len, input int lat);
    ev_t e;
    e.kind = kind; e.rnd = rnd; e.len = len; e.lat = lat;
    exp_q.push_back(e);
  endfunction

  // Expected event stream for one encryption. mix_stop > 0 ends the stream
  // after MixColumns of that round; sub_stop > 0 ends it before SubBytes of
  // that round. Both zero: full run ending in DONE.
  function automatic void push_enc(input int kd, input int sd, input int mix_stop, input int sub_stop);
    push_ev(EV_REQ, 0, kd + 1, -1);
    push_ev(EV_ADD, 0, 0, -1);
    for (int r = 1; r <= 10; r++) begin
      if (r == sub_stop) return;
      push_ev(EV_SBX, r, sd + 1, -1);
      push_ev(EV_SHIFT, r, 0, -1);
      if (r < 10) push_ev(EV_MIX, r, 0, -1);
      if (r == mix_stop) return;
      push_ev(EV_REQ, r, kd + 1, -1);
      push_ev(EV_ADD, r, 0, -1);
    end
    push_ev(EV_DONE, 10, 0, 51 + 11 * kd + 10 * sd);
  endfunction

  // Key expansion and sbox models: answer after a programmable delay.
  always @(negedge aes_clk) begin
    if (key_req_o) begin
      key_vld_i = (key_dly >= 0) && (kcnt == key_dly);
      kcnt++;
    end else begin
      key_vld_i = 1'b0;
      kcnt = 0;
    end
    if (sbox_en_o) begin
      sbox_done_i = (scnt == sbox_dly);
      scnt++;
    end else begin
      sbox_done_i = 1'b0;
      scnt = 0;
    end
  end

  function automatic void emit(input int kind, input int rnd, input int len, input int lat);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event_kind", kind, -1);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == e.kind) begin
        chk("event_round", rnd, e.rnd);
        if (e.len > 0) chk("handshake_len", len, e.len);
        if (e.lat >= 0) chk("latency", lat, e.lat);
      end
    end
  endfunction

  // Monitor
  logic req_prev = 1'b0, sbx_prev = 1'b0;
  int   req_len = 0, req_rnd = 0, sbx_len = 0, sbx_rnd = 0;

  always @(negedge aes_clk) begin
    if (reset) begin
      req_prev = 1'b0;
      sbx_prev = 1'b0;
    end else begin
      if (req_prev && !key_req_o) emit(EV_REQ, req_rnd, req_len, -1);
      if (key_req_o) begin
        req_len = req_prev ? req_len + 1 : 1;
        req_rnd = int'(round_num_o);
      end
      req_prev = key_req_o;
      if (sbx_prev && !sbox_en_o) emit(EV_SBX, sbx_rnd, sbx_len, -1);
      if (sbox_en_o) begin
        sbx_len = sbx_prev ? sbx_len + 1 : 1;
        sbx_rnd = int'(round_num_o);
      end
      sbx_prev = sbox_en_o;
      if (add_key_en_o)      emit(EV_ADD,   int'(round_num_o), 0, -1);
      if (shift_rows_en_o)   emit(EV_SHIFT, int'(round_num_o), 0, -1);
      if (mix_col_en_o)      emit(EV_MIX,   int'(round_num_o), 0, -1);
      if (cipher_text_rdy_o) emit(EV_DONE,  int'(round_num_o), 0, cyc - start_cyc);
      if (key_err_o)         emit(EV_ERR,   int'(round_num_o), 0, cyc - start_cyc);
    end
  end

  function automatic int outs();
    return int'({key_req_o, sbox_en_o, shift_rows_en_o, mix_col_en_o,
                 add_key_en_o, busy_o, cipher_text_rdy_o, key_err_o});
  endfunction

  task automatic start_pulse();
    @(negedge aes_clk);
    start_i = 1'b1;
    @(posedge aes_clk);
    #1;
    start_cyc = cyc;
    @(negedge aes_clk);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n;
    n = 0;
    while ((busy_o || exp_q.size() != 0) && n < max_cyc) begin
      @(negedge aes_clk);
      n++;
    end
    chk({name, "_done_in_time"}, int'(n < max_cyc), 1);
    chk({name, "_events_left"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge aes_clk);
  endtask

  initial begin
    int n;

    // Reset state
    repeat (3) @(negedge aes_clk);
    chk("reset_outputs", outs(), 0);
    chk("reset_round", int'(round_num_o), 0);
    reset = 1'b0;
    aes_core_en = 1'b1;
    @(negedge aes_clk);
    chk("idle_outputs", outs(), 0);

    // 1: zero-wait handshakes, 51-edge latency, busy low one edge later
    key_dly = 0; sbox_dly = 0;
    push_enc(0, 0, 0, 0);
    start_pulse();
    n = 0;
    while (!cipher_text_rdy_o && n < 200) begin
      @(negedge aes_clk);
      n++;
    end
    chk("t1_done_seen", int'(cipher_text_rdy_o), 1);
    chk("t1_busy_in_done", int'(busy_o), 1);
    @(negedge aes_clk);
    chk("t1_busy_after", int'(busy_o), 0);
    chk("t1_round_hold", int'(round_num_o), 10);
    wait_idle("t1", 50);

    // 2: key after 3 cycles, sbox after 2 cycles -> latency 104
    key_dly = 3; sbox_dly = 2;
    push_enc(3, 2, 0, 0);
    start_pulse();
    wait_idle("t2", 300);

    // 3: no key -> error after 255 KEY cycles, no ready
    key_dly = -1; sbox_dly = 0;
    push_ev(EV_REQ, 0, 255, -1);
    push_ev(EV_ERR, 0, 0, 255);
    start_pulse();
    wait_idle("t3", 400);
    chk("t3_outputs_idle", outs(), 0);

    // 4: enable dropped in round 5 MixColumns, then a clean run
    key_dly = 0; sbox_dly = 0;
    push_enc(0, 0, 5, 0);
    start_pulse();
    n = 0;
    while (!(mix_col_en_o && round_num_o == 4'd5) && n < 200) begin
      @(negedge aes_clk);
      n++;
    end
    chk("t4_mix5_seen", int'(mix_col_en_o), 1);
    aes_core_en = 1'b0;
    @(negedge aes_clk);
    chk("t4_abort_outputs", outs(), 0);
    chk("t4_abort_round", int'(round_num_o), 0);
    chk("t4_abort_events_left", exp_q.size(), 0);
    @(negedge aes_clk);
    aes_core_en = 1'b1;
    push_enc(0, 0, 0, 0);
    start_pulse();
    wait_idle("t4", 200);

    // 5: async reset mid-SUB of round 3, then a run with start pulses while busy
    key_dly = 0; sbox_dly = 2;
    push_enc(0, 2, 0, 3);
    start_pulse();
    n = 0;
    while (!(sbox_en_o && round_num_o == 4'd3) && n < 200) begin
      @(negedge aes_clk);
      n++;
    end
    chk("t5_sub3_seen", int'(sbox_en_o), 1);
    chk("t5_events_before_reset", exp_q.size(), 0);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_outputs", outs(), 0);
    chk("t5_async_round", int'(round_num_o), 0);
    repeat (2) @(negedge aes_clk);
    #2 reset = 1'b0;
    @(negedge aes_clk);
    sbox_dly = 0;
    push_enc(0, 0, 0, 0);
    start_pulse();
    for (int i = 0; i < 40; i++) begin
      @(negedge aes_clk);
      start_i = (i == 4 || i == 19 || i == 38);
    end
    @(negedge aes_clk);
    start_i = 1'b0;
    wait_idle("t5", 200);

    // 6: key arrives in the cycle the timeout expires -> no error
    key_dly = 254; sbox_dly = 0;
    push_enc(254, 0, 0, 0);
    start_pulse();
    wait_idle("t6", 4000);
    chk("t6_outputs_idle", outs(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
